// File: rtl/osc_meas_pkg.sv
`default_nettype none
// ============================================================================
// Module   : osc_meas_pkg
// Brief    : Shared types and default widths for the oscillator frequency
//            counter (measurement FSM states, parameter defaults).
// Revision : 1.0 - initial release
// ============================================================================
package osc_meas_pkg;

  // Measurement sequencer states
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARM     = 2'd1,
    S_MEASURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam int CNT_W_DEF       = 16;
  localparam int WIN_W_DEF       = 16;
  localparam int SYNC_STAGES_DEF = 2;

endpackage : osc_meas_pkg
`default_nettype wire

// File: rtl/osc_edge_sync.sv
`default_nettype none
// ============================================================================
// Module   : osc_edge_sync
// Brief    : Multi-stage synchronizer for an asynchronous input followed by a
//            rising-edge detector. EDGE is high for one CLK cycle for each
//            0->1 transition seen at the last synchronizer stage.
// Revision : 1.0 - initial release
// ============================================================================
module osc_edge_sync
  import osc_meas_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF  // must be >= 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic D,
  output logic EDGE
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Shift the async input through the sync chain and keep the previous
  // synchronized level for edge detection; runs continuously in all states.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], D};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign EDGE = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule : osc_edge_sync
`default_nettype wire

// File: rtl/osc_freq_counter.sv
`default_nettype none
// ============================================================================
// Module   : osc_freq_counter
// Brief    : Counts OSC_IN rising edges over a programmable window of CLK
//            cycles and presents the count through a VALID/ACK handshake.
//            Sequence: IDLE -> ARM (flush synchronizer) -> MEASURE -> DONE.
// Revision : 1.0 - initial release
// ============================================================================
module osc_freq_counter
  import osc_meas_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int WIN_W       = WIN_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             OSC_IN,
  input  logic             EN,
  input  logic             START,
  input  logic [WIN_W-1:0] WIN,
  output logic             BUSY,
  output logic             VALID,
  output logic [CNT_W-1:0] COUNT,
  output logic             OVF,
  input  logic             ACK
);

  localparam int               c_ARM_W    = $clog2(SYNC_STAGES + 1);
  localparam logic [c_ARM_W-1:0] c_ARM_LAST = c_ARM_W'(SYNC_STAGES - 1);
  localparam logic [CNT_W-1:0] c_CNT_MAX  = '1;
  localparam logic [WIN_W-1:0] c_WIN_LAST = WIN_W'(1);

  state_t             r_state;
  logic [c_ARM_W-1:0] r_arm_cnt;
  logic [WIN_W-1:0]   r_win_cnt;   // remaining MEASURE cycles, loaded from WIN
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf;
  logic               r_busy;
  logic               r_valid;
  logic               w_edge;

  osc_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .CLK  (CLK),
    .RST  (RST),
    .D    (OSC_IN),
    .EDGE (w_edge)
  );

  // Measurement sequencer with window timer, saturating edge counter and
  // registered status outputs; EN low forces everything back to idle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_arm_cnt <= '0;
      r_win_cnt <= '0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
    end else if (!EN) begin
      r_state   <= S_IDLE;
      r_arm_cnt <= '0;
      r_win_cnt <= '0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // A zero-length window is not a valid request
          if (START && (WIN != '0)) begin
            r_state   <= S_ARM;
            r_win_cnt <= WIN;
            r_arm_cnt <= '0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
            r_busy    <= 1'b1;
          end
        end
        S_ARM: begin
          // Let edges already in flight in the sync chain drain uncounted
          if (r_arm_cnt == c_ARM_LAST) begin
            r_state <= S_MEASURE;
          end else begin
            r_arm_cnt <= r_arm_cnt + 1'b1;
          end
        end
        S_MEASURE: begin
          if (w_edge) begin
            if (r_cnt == c_CNT_MAX) begin
              r_ovf <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          // The edge seen in the last window cycle is still counted above
          if (r_win_cnt == c_WIN_LAST) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_valid <= 1'b1;
          end else begin
            r_win_cnt <= r_win_cnt - 1'b1;
          end
        end
        S_DONE: begin
          // ACK wins over a simultaneous START; the START is dropped
          if (ACK) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign BUSY  = r_busy;
  assign VALID = r_valid;
  assign COUNT = r_cnt;
  assign OVF   = r_ovf;

endmodule : osc_freq_counter
`default_nettype wire

// File: tb/tb_osc_freq_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_osc_freq_counter
// Brief    : Scoreboard bench for osc_freq_counter. Two instances (16-bit and
//            4-bit counter) share all inputs; OSC_IN follows a pre-computed
//            waveform so the expected edge count of each window is derived
//            from the waveform samples before the run completes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_osc_freq_counter;

  localparam int S  = 2;
  localparam int NW = 32768;

  typedef struct {
    int cnt;
    bit ovf;
    int vcyc;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        OSC_IN = 1'b0;
  logic        EN = 1'b1;
  logic        START = 1'b0;
  logic        ACK = 1'b0;
  logic [15:0] WIN = '0;

  logic        BUSY_A, VALID_A, OVF_A;
  logic [15:0] COUNT_A;
  logic        BUSY_B, VALID_B, OVF_B;
  logic [3:0]  COUNT_B;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   wave [NW];
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t h_a, h_b;
  bit   pv_a = 1'b0;
  bit   pv_b = 1'b0;

  osc_freq_counter #(.CNT_W(16), .WIN_W(16), .SYNC_STAGES(S)) u_dut_a (
    .CLK(CLK), .RST(RST), .OSC_IN(OSC_IN), .EN(EN), .START(START), .WIN(WIN),
    .BUSY(BUSY_A), .VALID(VALID_A), .COUNT(COUNT_A), .OVF(OVF_A), .ACK(ACK)
  );

  osc_freq_counter #(.CNT_W(4), .WIN_W(16), .SYNC_STAGES(S)) u_dut_b (
    .CLK(CLK), .RST(RST), .OSC_IN(OSC_IN), .EN(EN), .START(START), .WIN(WIN),
    .BUSY(BUSY_B), .VALID(VALID_B), .COUNT(COUNT_B), .OVF(OVF_B), .ACK(ACK)
  );

  always #5 CLK = ~CLK;

  // cyc numbers the rising edges; during the interval after edge k OSC_IN = wave[k]
  always @(posedge CLK) begin
    cyc = cyc + 1;
    #1 OSC_IN = wave[cyc % NW];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_periodic(input int p, input int ph);
    for (int k = cyc + 1; k < NW; k++) wave[k] = (((k + ph) % p) >= (p / 2));
  endtask

  task automatic set_const(input bit v);
    for (int k = cyc + 1; k < NW; k++) wave[k] = v;
  endtask

  task automatic set_random();
    for (int k = cyc + 1; k < NW; k++) wave[k] = 1'($urandom_range(0, 1));
  endtask

  // Rising transitions between consecutive CLK samples of OSC_IN over the
  // window: sample pairs (m-1, m) for edges m = e+1 .. e+w, where sample at
  // edge m is wave[m-1].
  function automatic int edges_in_window(input int e, input int w);
    int n = 0;
    for (int j = e - 1; j <= e + w - 2; j++)
      if (!wave[j] && wave[j + 1]) n++;
    return n;
  endfunction

  function automatic exp_t make_exp(input int n, input int maxv, input int vc);
    exp_t x;
    x.cnt  = (n > maxv) ? maxv : n;
    x.ovf  = (n > maxv);
    x.vcyc = vc;
    return x;
  endfunction

  // Scoreboard monitor, 16-bit instance
  always @(negedge CLK) begin
    if (!RST) begin
      if (VALID_A && !pv_a) begin
        chk("a_valid_expected", (q_a.size() > 0), 1);
        if (q_a.size() > 0) begin
          h_a = q_a.pop_front();
          chk("a_count", COUNT_A, h_a.cnt);
          chk("a_ovf", OVF_A, h_a.ovf);
          chk("a_latency_cycle", cyc, h_a.vcyc);
          chk("a_busy_in_done", BUSY_A, 0);
        end
      end else if (VALID_A) begin
        chk("a_count_hold", COUNT_A, h_a.cnt);
        chk("a_ovf_hold", OVF_A, h_a.ovf);
      end
    end
    pv_a = VALID_A;
  end

  // Scoreboard monitor, 4-bit instance
  always @(negedge CLK) begin
    if (!RST) begin
      if (VALID_B && !pv_b) begin
        chk("b_valid_expected", (q_b.size() > 0), 1);
        if (q_b.size() > 0) begin
          h_b = q_b.pop_front();
          chk("b_count", COUNT_B, h_b.cnt);
          chk("b_ovf", OVF_B, h_b.ovf);
          chk("b_latency_cycle", cyc, h_b.vcyc);
        end
      end else if (VALID_B) begin
        chk("b_count_hold", COUNT_B, h_b.cnt);
        chk("b_ovf_hold", OVF_B, h_b.ovf);
      end
    end
    pv_b = VALID_B;
  end

  task automatic do_run(input int w, input int hold, input bit mid_start, input bit start_ack);
    int e, n;
    bit got;
    @(negedge CLK);
    START = 1'b1;
    WIN   = 16'(w);
    e     = cyc + 1;
    n     = edges_in_window(e, w);
    q_a.push_back(make_exp(n, 65535, e + S + w));
    q_b.push_back(make_exp(n, 15, e + S + w));
    @(negedge CLK);
    START = 1'b0;
    chk("busy_after_start_a", BUSY_A, 1);
    chk("busy_after_start_b", BUSY_B, 1);
    got = 1'b0;
    for (int i = 0; i < w + S + 10 && !got; i++) begin
      if (VALID_A) begin
        got = 1'b1;
      end else begin
        if (mid_start && (i == 5 || i == 9)) begin
          START = 1'b1;
          WIN   = 16'($urandom_range(1, 300));
        end else begin
          START = 1'b0;
        end
        @(negedge CLK);
      end
    end
    START = 1'b0;
    if (!got) begin
      chk("valid_within_budget", got, 1);
      return;
    end
    repeat (hold) @(negedge CLK);
    ACK = 1'b1;
    if (start_ack) begin
      START = 1'b1;
      WIN   = 16'd20;
    end
    @(negedge CLK);
    ACK   = 1'b0;
    START = 1'b0;
    chk("valid_after_ack_a", VALID_A, 0);
    chk("valid_after_ack_b", VALID_B, 0);
    chk("count_kept_after_ack", COUNT_A, make_exp(n, 65535, 0).cnt);
    if (start_ack) begin
      chk("no_run_after_start_ack", BUSY_A, 0);
      @(negedge CLK);
      chk("still_idle_after_start_ack", BUSY_A, 0);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, {BUSY_A, BUSY_B}, 0);
    chk({tag, "_valid"}, {VALID_A, VALID_B}, 0);
    chk({tag, "_count"}, {COUNT_A, 4'(COUNT_B)}, 0);
    chk({tag, "_ovf"}, {OVF_A, OVF_B}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int p, w;
    set_const(1'b0);
    repeat (3) @(negedge CLK);
    chk_all_zero("reset");
    RST = 1'b0;

    // Square wave of period 4 with VALID held before ACK
    set_periodic(4, 0);
    repeat (10) @(negedge CLK);
    do_run(100, 5, 1'b0, 1'b0);

    // Static levels give no counts
    set_const(1'b0);
    repeat (5) @(negedge CLK);
    do_run(50, 1, 1'b0, 1'b0);
    set_const(1'b1);
    repeat (5) @(negedge CLK);
    do_run(50, 0, 1'b0, 1'b0);

    // Period 2 saturates the 4-bit instance
    set_periodic(2, 1);
    repeat (4) @(negedge CLK);
    do_run(64, 2, 1'b0, 1'b0);

    // START with WIN=0 is ignored
    @(negedge CLK);
    START = 1'b1;
    WIN   = 16'd0;
    @(negedge CLK);
    START = 1'b0;
    chk("win0_busy", BUSY_A, 0);
    @(negedge CLK);
    chk("win0_busy_later", BUSY_A, 0);

    // Extra START pulses while measuring, then START+ACK together
    set_periodic(4, 1);
    do_run(80, 0, 1'b1, 1'b0);
    do_run(30, 0, 1'b0, 1'b1);

    // EN abort at about MEASURE cycle 20
    @(negedge CLK);
    START = 1'b1;
    WIN   = 16'd100;
    @(negedge CLK);
    START = 1'b0;
    repeat (S + 20) @(negedge CLK);
    chk("count_before_abort_nonzero", (COUNT_A != 0), 1);
    EN = 1'b0;
    @(negedge CLK);
    chk_all_zero("abort");
    EN = 1'b1;
    do_run(60, 0, 1'b0, 1'b0);

    // Asynchronous reset mid-measurement
    @(negedge CLK);
    START = 1'b1;
    WIN   = 16'd100;
    @(negedge CLK);
    START = 1'b0;
    repeat (S + 12) @(negedge CLK);
    #2 RST = 1'b1;
    #1 chk_all_zero("async_reset");
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    set_periodic(4, 0);
    repeat (3) @(negedge CLK);
    do_run(40, 0, 1'b0, 1'b0);

    // Randomized runs
    for (int r = 0; r < 15; r++) begin
      case ($urandom_range(0, 2))
        0: begin
          p = $urandom_range(2, 9);
          set_periodic(p, $urandom_range(0, p - 1));
        end
        1: set_random();
        default: set_const(1'($urandom_range(0, 1)));
      endcase
      repeat ($urandom_range(0, 3)) @(negedge CLK);
      w = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : $urandom_range(1, 200);
      do_run(w, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (5) @(negedge CLK);
    chk("queue_a_drained", q_a.size(), 0);
    chk("queue_b_drained", q_b.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_osc_freq_counter
`default_nettype wire
